vec_pacer: RTL and testbench
============================

VEC_PACER -- requirements
Module: vec_pacer

Interface
REQ-001 Parameter VEC_W, default 20, width of paced feature vector.
REQ-002 Parameter PERIOD_W, default 16, width of strobe-period field.
REQ-003 Parameter CNT_W, default 16, width of burst count field.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 cfg_period  input  PERIOD_W  strobe spacing P in clk cycles; latched on start.
REQ-007 cfg_count  input  CNT_W  strobes per burst N; latched on start.
REQ-008 cfg_mode  input  2  00 continuous, 01 burst, 10 single-shot, 11 treated as 00; latched on start.
REQ-009 start  input  1  one-cycle request to begin pacing.
REQ-010 stop  input  1  one-cycle request to abort pacing.
REQ-011 src_vec  input  VEC_W  vector from upstream (e.g. feature extractor).
REQ-012 src_valid  input  1  src_vec valid.
REQ-013 src_ready  output  1  one-entry buffer can accept.
REQ-014 vec_out  output  VEC_W  registered vector to DNN vec_in.
REQ-015 dv_out  output  1  one-cycle strobe, vec_out valid (drives DNN dv_in).
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  one-cycle pulse on burst/single-shot completion.
REQ-018 underrun  output  1  sticky: a period tick found the buffer empty.

Function
REQ-019 States: IDLE, RUN; IDLE->RUN on start; RUN->IDLE on stop, on completion, or never (continuous mode without stop).
REQ-020 Effective period Pe = max(cfg_period,1); cfg_period=0 behaves as 1 (strobe candidate every cycle).
REQ-021 Start sampled in cycle t: first period tick in cycle t+Pe, then every Pe cycles while RUN; default P=21 gives one strobe per 21 cycles.
REQ-022 Tick with buffer full: dv_out=1 and vec_out=buffer contents in the cycle after the tick edge (1-cycle latency); buffer emptied.
REQ-023 Tick with buffer empty: no strobe, underrun set, tick not counted toward N.
REQ-024 src_ready = !buf_full; transfer when src_valid && src_ready; accepted in IDLE (prefill) and RUN.
REQ-025 Same-cycle strobe and src transfer are legal only because src_ready is low when full; no bypass path (empty buffer at tick never forwards src_vec).
REQ-026 vec_out holds last emitted value between strobes; dv_out low except strobe cycles.
REQ-027 Burst: after N-th emitted strobe, done pulses in the same cycle as that dv_out, state -> IDLE; N=0 behaves as 1.
REQ-028 Single-shot: identical to burst with N=1.
REQ-029 stop in RUN: IDLE next cycle, no further strobes, no done, buffer contents retained.
REQ-030 start while RUN ignored; start and stop same cycle in IDLE: stop wins, stay IDLE.
REQ-031 start clears underrun, strobe count and period counter; does not clear buffer.

Reset
REQ-032 reset low: state IDLE, buffer empty, vec_out=0, dv_out=0, busy=0, done=0, underrun=0, src_ready=0.
REQ-033 reset asserted mid-burst aborts immediately; no strobe or done emitted after release until a new start.
REQ-034 src_ready rises in the first cycle after reset release.

Configuration
REQ-035 Macro VEC_PACER_UNDERRUN_CNT_EN defined: adds output underrun_cnt [CNT_W-1:0], saturating count of empty-buffer ticks, cleared by start and reset.
REQ-036 Macro undefined: port and counter absent; sticky underrun flag only; all other behaviour identical.

Verification
REQ-037 P=21, mode 00, src_valid held high with incrementing vectors -> dv_out every 21 cycles, first 21 cycles after start, vec_out 0,1,2,... in order.
REQ-038 P=4, mode 01, N=3, source always valid -> exactly 3 strobes 4 cycles apart, done coincident with 3rd dv_out, busy falls next cycle.
REQ-039 P=5, mode 00, src_valid low for 12 cycles after start -> ticks 1 and 2 empty, underrun=1 (underrun_cnt=2 with macro), strobes resume when data arrives.
REQ-040 P=3, mode 01, N=10, stop after 2nd strobe -> no further dv_out, no done, buffered vector emitted first after restart.
REQ-041 reset driven low between strobes of a P=6 burst -> all outputs 0 immediately, src_ready 0 during reset, no dv_out until new start.
REQ-042 cfg_period=0, mode 10 -> single strobe in the cycle after start, done same cycle.

Source files
------------

// File: rtl/vec_pacer.sv
// vec_pacer: paces a one-entry buffered feature vector onto a DNN input.
// Optional saturating underrun counter: VEC_PACER_UNDERRUN_CNT_EN.
module vec_pacer #(
  parameter int VEC_W    = 20,
  parameter int PERIOD_W = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [CNT_W-1:0]    cfg_count,
  input  logic [1:0]          cfg_mode,
  input  logic                start,
  input  logic                stop,
  input  logic [VEC_W-1:0]    src_vec,
  input  logic                src_valid,
  output logic                src_ready,
  output logic [VEC_W-1:0]    vec_out,
  output logic                dv_out,
  output logic                busy,
  output logic                done,
`ifdef VEC_PACER_UNDERRUN_CNT_EN
  output logic [CNT_W-1:0]    underrun_cnt,
`endif
  output logic                underrun
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0]    lim_q, lim_d;
  logic [CNT_W-1:0]    scnt_q, scnt_d;
  logic                cont_q, cont_d;
  logic [VEC_W-1:0]    buf_q, buf_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic                full_q, full_d;
  logic                dv_q, dv_d;
  logic                done_q, done_d;
  logic                und_q, und_d;
  logic                rdy_q;

  logic                go;
  logic                tick;
  logic                emit;
  logic                take;
  logic [PERIOD_W-1:0] pe_m1;
  logic [CNT_W-1:0]    n_m1;
  logic                cont_cfg;

  assign pe_m1 = (cfg_period == '0) ? '0
               : cfg_period - PERIOD_W'(1);

  // single-shot is a burst of one; zero count also means one
  assign n_m1 = (cfg_mode == 2'b10) ? '0
              : (cfg_count == '0)   ? '0
              : cfg_count - CNT_W'(1);

  assign cont_cfg = (cfg_mode[1] == cfg_mode[0]);

  assign go   = (state_q == IDLE) && start && !stop;
  assign tick = (state_q == RUN) && !stop && !done_q
             && (tcnt_q == '0);
  assign emit = tick && full_q;
  assign take = src_valid && src_ready;

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    tcnt_d  = tcnt_q;
    lim_d   = lim_q;
    scnt_d  = scnt_q;
    cont_d  = cont_q;
    buf_d   = buf_q;
    vec_d   = vec_q;
    full_d  = full_q;
    dv_d    = 1'b0;
    done_d  = 1'b0;
    und_d   = und_q;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = RUN;
          per_d   = pe_m1;
          tcnt_d  = pe_m1;
          lim_d   = n_m1;
          cont_d  = cont_cfg;
          scnt_d  = '0;
          und_d   = 1'b0;
        end
      end
      RUN: begin
        // done_q marks the final strobe cycle; leave RUN one cycle later
        if (stop || done_q) begin
          state_d = IDLE;
        end else if (tick) begin
          tcnt_d = per_q;
        end else begin
          tcnt_d = tcnt_q - PERIOD_W'(1);
        end
        if (emit) begin
          dv_d   = 1'b1;
          vec_d  = buf_q;
          scnt_d = scnt_q + CNT_W'(1);
          done_d = !cont_q && (scnt_q == lim_q);
        end
        if (tick && !full_q) begin
          und_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      full_d = 1'b1;
      buf_d  = src_vec;
    end else if (emit) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      per_q   <= '0;
      tcnt_q  <= '0;
      lim_q   <= '0;
      scnt_q  <= '0;
      cont_q  <= 1'b0;
      buf_q   <= '0;
      vec_q   <= '0;
      full_q  <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      und_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      tcnt_q  <= tcnt_d;
      lim_q   <= lim_d;
      scnt_q  <= scnt_d;
      cont_q  <= cont_d;
      buf_q   <= buf_d;
      vec_q   <= vec_d;
      full_q  <= full_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
      und_q   <= und_d;
      rdy_q   <= 1'b1;
    end
  end

`ifdef VEC_PACER_UNDERRUN_CNT_EN
  logic [CNT_W-1:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (go) begin
      ucnt_d = '0;
    end else if (tick && !full_q && (ucnt_q != '1)) begin
      ucnt_d = ucnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

  assign src_ready = rdy_q && !full_q;
  assign vec_out   = vec_q;
  assign dv_out    = dv_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign underrun  = und_q;

endmodule

// File: tb/tb_vec_pacer.sv
// tb_vec_pacer: table-driven pacing scenarios plus hand-built corner cases,
// with a vector scoreboard fed on every source transfer.
module tb_vec_pacer;
  localparam int VW = 20;
  localparam int PW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] cfg_period = '0;
  logic [CW-1:0] cfg_count = '0;
  logic [1:0]    cfg_mode = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [VW-1:0] src_vec = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [VW-1:0] vec_out;
  logic          dv_out;
  logic          busy;
  logic          done;
  logic          underrun;
`ifdef VEC_PACER_UNDERRUN_CNT_EN
  logic [CW-1:0] underrun_cnt;
`endif

  vec_pacer #(.VEC_W(VW), .PERIOD_W(PW), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .cfg_period(cfg_period),
    .cfg_count(cfg_count),
    .cfg_mode(cfg_mode),
    .start(start),
    .stop(stop),
    .src_vec(src_vec),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .vec_out(vec_out),
    .dv_out(dv_out),
    .busy(busy),
    .done(done),
`ifdef VEC_PACER_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic [VW-1:0] sb[$];
  int stb_cyc[$];
  int done_cyc[$];
  bit inc_pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // strobe/done monitor and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (dv_out) begin
      stb_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL sb_vec: got %0d expected none queued", vec_out);
      end else begin
        chk("sb_vec", 32'(vec_out), 32'(sb.pop_front()));
      end
    end
    if (done) done_cyc.push_back(cyc);
    if (src_valid && src_ready) begin
      sb.push_back(src_vec);
      inc_pend = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (inc_pend) begin
      src_vec = src_vec + VW'(1);
      inc_pend = 1'b0;
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb.delete();
    step(3);
    reset = 1'b1;
    step(2);
  endtask

  task automatic start_run(int p, int n, int m, output int s);
    cfg_period = PW'(p);
    cfg_count  = CW'(n);
    cfg_mode   = 2'(m);
    start = 1'b1;
    step(1);
    start = 1'b0;
    s = cyc;
    stb_cyc.delete();
    done_cyc.delete();
  endtask

  typedef struct {
    int p;
    int n;
    int m;
    int run;
    int exp_n;
    bit exp_done;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int s;
    int pe;
    bit seen;

    tbl[0] = '{21, 0, 0, 87, 4, 1'b0};
    tbl[1] = '{4,  3, 1, 30, 3, 1'b1};
    tbl[2] = '{0,  5, 2, 10, 1, 1'b1};
    tbl[3] = '{2,  0, 1, 10, 1, 1'b1};
    tbl[4] = '{3,  0, 3, 20, 6, 1'b0};
    tbl[5] = '{2,  4, 1, 20, 4, 1'b1};

    // power-on reset values
    @(negedge clk);
    chk("rst_vec_out", 32'(vec_out), 0);
    chk("rst_dv_out", 32'(dv_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_src_ready", 32'(src_ready), 0);
    @(posedge clk);
    #1;

    src_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_reset();
      start_run(tbl[i].p, tbl[i].n, tbl[i].m, s);
      step(tbl[i].run);
      pe = (tbl[i].p == 0) ? 1 : tbl[i].p;
      chk($sformatf("t%0d_nstrobe", i), 32'(stb_cyc.size()),
          32'(tbl[i].exp_n));
      for (int k = 0; k < stb_cyc.size() && k < tbl[i].exp_n; k++)
        chk($sformatf("t%0d_off%0d", i, k), 32'(stb_cyc[k] - s),
            32'((k + 1) * pe));
      chk($sformatf("t%0d_ndone", i), 32'(done_cyc.size()),
          32'(tbl[i].exp_done));
      if (tbl[i].exp_done && done_cyc.size() > 0)
        chk($sformatf("t%0d_done_off", i), 32'(done_cyc[0] - s),
            32'(tbl[i].exp_n * pe));
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(!tbl[i].exp_done));
      chk($sformatf("t%0d_underrun", i), 32'(underrun), 0);
    end

    // busy stays up with done, falls the cycle after
    do_reset();
    start_run(4, 3, 1, s);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      $display("FAIL done_wait: got no done expected done within 40");
    end else begin
      chk("done_dv", 32'(dv_out), 1);
      chk("done_busy", 32'(busy), 1);
      @(negedge clk);
      chk("after_done_busy", 32'(busy), 0);
      chk("after_done_pulse", 32'(done), 0);
    end
    @(posedge clk);
    #1;

    // underrun: source idle for the first two ticks
    src_valid = 1'b0;
    do_reset();
    start_run(5, 0, 0, s);
    step(11);
    src_valid = 1'b1;
    step(10);
    chk("und_nstrobe", 32'(stb_cyc.size()), 2);
    if (stb_cyc.size() >= 2) begin
      chk("und_off0", 32'(stb_cyc[0] - s), 15);
      chk("und_off1", 32'(stb_cyc[1] - s), 20);
    end
    chk("und_flag", 32'(underrun), 1);
`ifdef VEC_PACER_UNDERRUN_CNT_EN
    chk("und_cnt", 32'(underrun_cnt), 2);
`endif
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2);
    start_run(5, 0, 0, s);
    @(negedge clk);
    chk("und_cleared", 32'(underrun), 0);
`ifdef VEC_PACER_UNDERRUN_CNT_EN
    chk("und_cnt_cleared", 32'(underrun_cnt), 0);
`endif
    @(posedge clk);
    #1;
    stop = 1'b1;
    step(1);
    stop = 1'b0;

    // stop mid-burst keeps the buffered vector for the next run
    do_reset();
    start_run(3, 10, 1, s);
    step(7);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(15);
    chk("stop_nstrobe", 32'(stb_cyc.size()), 2);
    chk("stop_ndone", 32'(done_cyc.size()), 0);
    chk("stop_busy", 32'(busy), 0);
    src_valid = 1'b0;
    start_run(3, 0, 2, s);
    step(5);
    chk("restart_nstrobe", 32'(stb_cyc.size()), 1);
    if (stb_cyc.size() >= 1)
      chk("restart_off", 32'(stb_cyc[0] - s), 3);
    chk("restart_ndone", 32'(done_cyc.size()), 1);
    chk("restart_sb_empty", 32'(sb.size()), 0);

    // asynchronous reset between strobes of a burst
    src_valid = 1'b1;
    do_reset();
    start_run(6, 5, 1, s);
    step(8);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_vec_out", 32'(vec_out), 0);
    chk("mid_rst_dv_out", 32'(dv_out), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_underrun", 32'(underrun), 0);
    chk("mid_rst_src_ready", 32'(src_ready), 0);
    @(posedge clk);
    #1;
    step(2);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_src_ready0", 32'(src_ready), 0);
    @(negedge clk);
    chk("rel_src_ready1", 32'(src_ready), 1);
    @(posedge clk);
    #1;
    stb_cyc.delete();
    done_cyc.delete();
    step(20);
    chk("post_rst_nstrobe", 32'(stb_cyc.size()), 0);
    chk("post_rst_ndone", 32'(done_cyc.size()), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // start and stop together in IDLE: stop wins
    cfg_period = PW'(2);
    cfg_mode = 2'b00;
    start = 1'b1;
    stop = 1'b1;
    step(1);
    start = 1'b0;
    stop = 1'b0;
    stb_cyc.delete();
    step(8);
    chk("ss_busy", 32'(busy), 0);
    chk("ss_nstrobe", 32'(stb_cyc.size()), 0);

    // a second start while running is ignored
    start_run(6, 0, 0, s);
    step(3);
    cfg_period = PW'(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(9);
    chk("rs_nstrobe", 32'(stb_cyc.size()), 2);
    if (stb_cyc.size() >= 2) begin
      chk("rs_off0", 32'(stb_cyc[0] - s), 6);
      chk("rs_off1", 32'(stb_cyc[1] - s), 12);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
